// File: rtl/ifu_fetch.sv
// Instruction fetch stage: sequential PC generation, imem request/response handling with
// in-order responses, a small fetch buffer feeding decode, and stall/flush handling.
module ifu_fetch #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     INSTR_LEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_LEN-1:0] imem_rsp_data,
    output logic [INSTR_LEN-1:0] instr,
    output logic                 instr_valid,
    output logic [XLEN-1:0]      instr_tag,
    input  logic                 pipe_stall,
    input  logic                 pipe_flush,
    input  logic [XLEN-1:0]      redirect_pc
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CrW  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]      rsp_pc_q, rsp_pc_d;
    logic [OutW-1:0]      out_q, out_d;
    logic [OutW-1:0]      drop_q, drop_d;
    logic [PtrW:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]        rd_ptr_q, rd_ptr_d;
    logic [INSTR_LEN-1:0] mem_data_q [FIFO_DEPTH];
    logic [XLEN-1:0]      mem_tag_q  [FIFO_DEPTH];

    logic            run;
    logic            flush_en;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [PtrW:0]   fifo_count;
    logic [OutW-1:0] live;
    logic [CrW-1:0]  credit_sum;
    logic            out_ok;
    logic            credit_ok;
    logic [XLEN-1:0] redirect_aligned;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};

    // Live in-flight requests each reserve a buffer slot; stale ones will be dropped.
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign live       = out_q - drop_q;
    assign credit_sum = CrW'(live) + CrW'(fifo_count);
    assign out_ok     = out_q < OutW'(MAX_OUTSTANDING);
    assign credit_ok  = credit_sum < CrW'(FIFO_DEPTH);

    assign flush_en = run & pipe_flush;
    assign req_fire = imem_req_valid & imem_req_ready;
    assign push     = imem_rsp_valid & ~flush_en & (drop_q == '0);
    assign pop      = instr_valid & ~pipe_stall & ~pipe_flush;

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid   = fifo_count != '0;
    assign instr         = mem_data_q[rd_ptr_q[PtrW-1:0]];
    assign instr_tag     = mem_tag_q[rd_ptr_q[PtrW-1:0]];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StBoot;
        else        state_q <= state_d;
    end

    // FSM next state: BOOT lasts exactly one clock, RUN holds until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // FSM outputs: request only in RUN, never in a flush cycle, and only with credit.
    always_comb begin
        run            = (state_q == StRun);
        imem_req_valid = run & ~pipe_flush & out_ok & credit_ok;
    end

    // Next-state for PCs, in-flight bookkeeping and buffer pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q + OutW'(req_fire) - OutW'(imem_rsp_valid);
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush_en) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            // Everything still in flight after this cycle is stale.
            drop_d     = out_q - OutW'(imem_rsp_valid);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
            if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - OutW'(1'b1);
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(32'd4);
                wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1'b1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1'b1);
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Fetch buffer storage; cleared on reset so decode-facing outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_tag_q[i]  <= '0;
            end
        end else if (push) begin
            mem_data_q[wr_ptr_q[PtrW-1:0]] <= imem_rsp_data;
            mem_tag_q[wr_ptr_q[PtrW-1:0]]  <= rsp_pc_q;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_count < (PtrW + 1)'(FIFO_DEPTH)));
    a_rsp_expected : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (out_q != '0));
`endif

endmodule
